truth_table_scanner: RTL and testbench
======================================

// Module: truth_table_scanner
// PURPOSE
//  Sequential stimulus/capture stage wrapped around a 4-input combinational
//  function block (SoP/PoS guides). It walks every input combination, drives it
//  on vec, waits SETTLE cycles, then samples the block output s. It assembles
//  the captured truth table, compares it against an expected table and reports
//  pass/fail. It replaces hand-written #1 sweeps with a clocked, reusable checker.
// PARAMETERS
//  N_IN    4  number of function inputs; the table has 2**N_IN entries
//  SETTLE  1  wait cycles between driving vec and sampling s; legal range 1..15
// PORTS
//  clk         in   1          rising-edge clock (single clock domain)
//  reset       in   1          asynchronous, active-high reset
//  start       in   1          begin a scan; sampled only in IDLE
//  expect_tt   in   2**N_IN    expected table; bit i = f(i); captured on start
//  s           in   1          output of the function block under test
//  vec         out  N_IN       stimulus vector; {x,y,w,z} = vec[3:0], x is MSB
//  busy        out  1          high from the cycle after start until done
//  done        out  1          one-cycle pulse at end of scan
//  pass        out  1          1 if captured == expected; valid from done to next start
//  table_q     out  2**N_IN    captured truth table; bit i = s sampled at vec=i
//  fail_cnt    out  N_IN+1     number of mismatching entries (0..2**N_IN)
//  first_fail  out  N_IN       lowest index that mismatched; 0 if none
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; vec, table_q, fail_cnt, first_fail = 0;
//    busy, done, pass = 0. Reset mid-scan aborts the scan; no done is produced.
//  - States: IDLE, WAIT, SAMPLE, DONE. All outputs are registered.
//  - IDLE: if start=1, latch expect_tt into exp_q. Clear table_q, fail_cnt,
//    first_fail and pass. Set idx=0, vec=0, busy=1, wcnt=SETTLE. Go to WAIT.
//  - WAIT: decrement wcnt. When wcnt reaches 1, go to SAMPLE.
//    WAIT therefore lasts exactly SETTLE cycles.
//  - SAMPLE: table_q[idx] <= s. If s != exp_q[idx]: fail_cnt++, and if
//    fail_cnt==0 also set first_fail=idx. Then:
//      - if idx == 2**N_IN-1, go to DONE;
//      - else idx++, vec <= idx+1, reload wcnt, go to WAIT.
//  - vec changes only on the SAMPLE->WAIT edge (and on start). It is stable
//    throughout WAIT and SAMPLE.
//  - DONE: done=1 for exactly this one cycle. busy=0, pass = (fail_cnt==0),
//    computed including the last sample. Return to IDLE.
//  - Latency: if start is sampled at edge k, done is high after edge
//    k + 2**N_IN*(SETTLE+1) + 1. That is 33 edges for the defaults.
//  - start while busy or in DONE: ignored. Edits to expect_tt mid-scan: ignored (exp_q is used).
//  - start held high continuously: a new scan begins the cycle after DONE.
//  - After done: table_q, fail_cnt, first_fail and pass hold until the next start.
//  - fail_cnt width N_IN+1 so an all-mismatch count (16) cannot wrap.
//  - idx is N_IN bits and never wraps during a scan; the terminal check precedes the increment.
//  - vec holds the last index (2**N_IN-1) after a scan until the next start.
// STRUCTURE
//  - Shared header tt_defs.vh: state encodings ST_IDLE=2'd0, ST_WAIT=2'd1,
//    ST_SAMPLE=2'd2, ST_DONE=2'd3, and the default N_IN/SETTLE values.
//    Later guide stages reuse these.
//  - One sub-module, tt_index_counter: N_IN-bit counter with clear, inc and
//    a terminal flag. It drives vec and idx.
//  - Settle counter, FSM and compare logic stay in the top.
// TESTING
//  1. s tied to vec[3] (x), expect_tt=16'hFF00, start pulse
//     -> done after 33 edges, table_q=FF00, pass=1, fail_cnt=0.
//  2. s tied to vec[0] (z), expect_tt=16'hFF00
//     -> table_q=AAAA, fail_cnt=8, first_fail=1, pass=0.
//  3. s from the PoS guide function, expect_tt from the bench model
//     -> pass=1. Check vec steps 0..15 in order, each held SETTLE+1 cycles.
//  4. Assert reset at index 7 mid-scan -> all outputs 0 immediately,
//     no done pulse; a new start then completes normally.
//  5. start pulsed again at index 3 and expect_tt changed mid-scan
//     -> no restart, result matches the original expect_tt.
//  6. SETTLE=3, s tied to 0, expect_tt=16'h0001
//     -> done at edge k+65, fail_cnt=1, first_fail=0, pass=0.

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner and later guide stages.
// Provides the scan FSM state encoding and the default sizing values.
package truth_table_scanner_pkg;

  // Default number of function inputs and settle cycles per vector.
  localparam int unsigned NInDefault    = 4;
  localparam int unsigned SettleDefault = 1;

  // Encodings are fixed so other stages can decode a captured state value.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } tt_state_e;

endpackage

// File: rtl/truth_table_scanner_tt_index_counter.sv
// Index counter for the truth-table scanner.
// Ports:
//   clk_i  - rising-edge clock
//   rst_i  - asynchronous active-high reset
//   clr_i  - synchronous clear to zero (wins over inc_i)
//   inc_i  - increment by one
//   cnt_o  - current count (drives the stimulus vector and table index)
//   term_o - high when the count is at its all-ones terminal value
module tt_index_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o,
  output logic             term_o
);

  localparam logic [Width-1:0] CntOne = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = &cnt_q;

endmodule

// File: rtl/truth_table_scanner.sv
// Clocked truth-table scanner. Walks every input combination of a combinational
// block, holds each vector for SETTLE cycles, samples the block output, builds
// the captured table and compares it with an expected table latched at start.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-high reset; aborts any scan
//   start      - begin a scan (only honoured when idle)
//   expect_tt  - expected table, bit i = f(i); latched on start
//   s          - output of the block under test
//   vec        - stimulus vector, index of the entry being measured
//   busy       - scan in progress
//   done       - one-cycle end-of-scan pulse
//   pass       - captured table equals expected (valid from done to next start)
//   table_q    - captured table, bit i = s sampled at vec = i
//   fail_cnt   - number of mismatching entries
//   first_fail - lowest mismatching index, 0 if none
// SETTLE must be in 1..15.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned N_IN   = NInDefault,
  parameter int unsigned SETTLE = SettleDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expect_tt,
  input  logic                 s,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   table_q,
  output logic [N_IN:0]        fail_cnt,
  output logic [N_IN-1:0]      first_fail
);

  localparam logic [3:0]  SettleLd = 4'(SETTLE);
  localparam logic [N_IN:0] CntOne = (N_IN+1)'(1);

  tt_state_e state_q, state_d;

  logic [3:0]            wcnt_q, wcnt_d;
  logic [2**N_IN-1:0]    exp_q, exp_d;
  logic [2**N_IN-1:0]    table_d;
  logic [N_IN:0]         fail_cnt_q, fail_cnt_d;
  logic [N_IN-1:0]       first_fail_q, first_fail_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;

  logic                  cnt_clr, cnt_inc;
  logic [N_IN-1:0]       idx;
  logic                  idx_term;

  tt_index_counter #(
    .Width (N_IN)
  ) u_idx (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (idx),
    .term_o (idx_term)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StWait;
      StWait:   if (wcnt_q == 4'd1) state_d = StSample;
      StSample: state_d = idx_term ? StDone : StWait;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output / datapath next-state logic. Everything visible is registered, so
  // the done pulse and final pass flag appear on the edge that leaves StDone.
  always_comb begin
    wcnt_d       = wcnt_q;
    exp_d        = exp_q;
    table_d      = table_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          exp_d        = expect_tt;
          table_d      = '0;
          fail_cnt_d   = '0;
          first_fail_d = '0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          wcnt_d       = SettleLd;
          cnt_clr      = 1'b1;
        end
      end
      StWait: begin
        wcnt_d = wcnt_q - 4'd1;
      end
      StSample: begin
        table_d[idx] = s;
        if (s != exp_q[idx]) begin
          fail_cnt_d = fail_cnt_q + CntOne;
          // A zero count means this is the first mismatch of the scan.
          if (fail_cnt_q == '0) begin
            first_fail_d = idx;
          end
        end
        // Terminal check comes first so the index never wraps.
        if (!idx_term) begin
          cnt_inc = 1'b1;
          wcnt_d  = SettleLd;
        end
      end
      StDone: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        pass_d = (fail_cnt_q == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q       <= '0;
      exp_q        <= '0;
      table_q      <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      wcnt_q       <= wcnt_d;
      exp_q        <= exp_d;
      table_q      <= table_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign vec        = idx;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner (default and SETTLE=3 instances).
module tb_truth_table_scanner;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  fc;
    logic [3:0]  ff;
    logic        ps;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] exp_tt;
  logic        s;
  logic [3:0]  vec;
  logic        busy, done, pass;
  logic [15:0] table_q;
  logic [4:0]  fail_cnt;
  logic [3:0]  first_fail;

  logic        start3;
  logic [15:0] exp3;
  logic [3:0]  vec3;
  logic        busy3, done3, pass3;
  logic [15:0] table3;
  logic [4:0]  fail_cnt3;
  logic [3:0]  first_fail3;

  int   sel;
  int   n_checks;
  int   n_fail;
  int   dones;
  exp_t sb[$];

  // PoS guide function: (x|y|~z)&(~x|w|z)&(y|~w), with {x,y,w,z} = v[3:0].
  function automatic logic pos_f(input logic [3:0] v);
    logic x, y, w, z;
    {x, y, w, z} = v;
    return (x | y | ~z) & (~x | w | z) & (y | ~w);
  endfunction

  function automatic logic sfun(input int fsel, input logic [3:0] v);
    case (fsel)
      0:       return v[3];
      1:       return v[0];
      2:       return pos_f(v);
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input int fsel, input logic [15:0] ett);
    exp_t e;
    bit   found;
    found = 0;
    e.tt = '0;
    e.fc = '0;
    e.ff = '0;
    for (int i = 0; i < 16; i++) begin
      e.tt[i] = sfun(fsel, 4'(i));
      if (e.tt[i] != ett[i]) begin
        e.fc = e.fc + 5'd1;
        if (!found) begin
          e.ff  = 4'(i);
          found = 1;
        end
      end
    end
    e.ps = (e.fc == 5'd0);
    return e;
  endfunction

  assign s = sfun(sel, vec);

  truth_table_scanner #(
    .N_IN   (4),
    .SETTLE (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .expect_tt  (exp_tt),
    .s          (s),
    .vec        (vec),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .table_q    (table_q),
    .fail_cnt   (fail_cnt),
    .first_fail (first_fail)
  );

  truth_table_scanner #(
    .N_IN   (4),
    .SETTLE (3)
  ) dut3 (
    .clk        (clk),
    .reset      (reset),
    .start      (start3),
    .expect_tt  (exp3),
    .s          (1'b0),
    .vec        (vec3),
    .busy       (busy3),
    .done       (done3),
    .pass       (pass3),
    .table_q    (table3),
    .fail_cnt   (fail_cnt3),
    .first_fail (first_fail3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Scoreboard monitor: every done pulse pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_table", 32'(table_q), 32'(e.tt));
          check("sb_fail_cnt", 32'(fail_cnt), 32'(e.fc));
          check("sb_first_fail", 32'(first_fail), 32'(e.ff));
          check("sb_pass", 32'(pass), 32'(e.ps));
        end
      end
    end
  end

  // One scan on the default instance; returns edges from start to done.
  task automatic run_scan(input int fsel, input logic [15:0] ett, input bit trace,
                          input bit poke, output int lat);
    logic [3:0] vtr[32];
    bit         poked;
    int         nbad;
    poked = 0;
    @(negedge clk);
    sel    = fsel;
    exp_tt = ett;
    start  = 1'b1;
    sb.push_back(model(fsel, ett));
    @(posedge clk);
    #1;
    start  = 1'b0;
    vtr[0] = vec;
    check("busy_after_start", 32'(busy), 32'd1);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat < 32) vtr[lat] = vec;
      if (done) break;
      if (poke && !poked && vec == 4'd3) begin
        start  = 1'b1;
        exp_tt = ~ett;
        poked  = 1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (lat >= 200) check("scan_timeout", 32'(lat), 32'd33);
    if (trace) begin
      nbad = 0;
      for (int c = 0; c < 32; c++) if (vtr[c] !== 4'(c / 2)) nbad++;
      check("vec_sequence_bad_steps", 32'(nbad), 32'd0);
      check("vec_hold_last", 32'(vec), 32'd15);
    end
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    int dones_before;
    n_checks = 0;
    n_fail   = 0;
    dones    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    start3   = 1'b0;
    exp_tt   = '0;
    exp3     = '0;
    sel      = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {vec, busy, done, pass, table_q, fail_cnt, first_fail}, 32'd0);
    check("reset_outputs3", {vec3, busy3, done3, pass3, table3, fail_cnt3, first_fail3}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: s = x, expected FF00.
    run_scan(0, 16'hFF00, 1'b0, 1'b0, lat);
    check("t1_latency", 32'(lat), 32'd33);
    check("t1_table", 32'(table_q), 32'h0000FF00);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_fail_cnt", 32'(fail_cnt), 32'd0);

    // 2: s = z against FF00; results must hold after done.
    run_scan(1, 16'hFF00, 1'b0, 1'b0, lat);
    repeat (3) @(posedge clk);
    #1;
    check("t2_table", 32'(table_q), 32'h0000AAAA);
    check("t2_fail_cnt", 32'(fail_cnt), 32'd8);
    check("t2_first_fail", 32'(first_fail), 32'd1);
    check("t2_pass", 32'(pass), 32'd0);
    check("t2_busy_idle", 32'(busy), 32'd0);

    // 3: PoS function against the bench model, with vector trace.
    run_scan(2, model(2, 16'h0).tt, 1'b1, 1'b0, lat);
    check("t3_pass", 32'(pass), 32'd1);

    // 4: reset in the middle of a scan at index 7.
    @(negedge clk);
    sel    = 1;
    exp_tt = 16'hFF00;
    start  = 1'b1;
    sb.push_back(model(1, 16'hFF00));
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (vec != 4'd7 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t4_reach_idx7", 32'(vec), 32'd7);
    check("t4_busy_before", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t4_async_clear", {vec, busy, done, pass, table_q, fail_cnt, first_fail}, 32'd0);
    void'(sb.pop_back());
    dones_before = dones;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("t4_no_done", 32'(dones), 32'(dones_before));
    run_scan(1, 16'hAAAA, 1'b0, 1'b0, lat);
    check("t4_restart_latency", 32'(lat), 32'd33);
    check("t4_restart_pass", 32'(pass), 32'd1);

    // 5: start re-pulsed and expect_tt flipped at index 3; both ignored.
    run_scan(0, 16'hFF00, 1'b0, 1'b1, lat);
    check("t5_latency", 32'(lat), 32'd33);
    check("t5_pass", 32'(pass), 32'd1);

    // 6: SETTLE=3 instance, s = 0, expected 0001.
    @(negedge clk);
    exp3   = 16'h0001;
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    exp3   = 16'hFFFF;
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      n++;
      #1;
      if (done3) break;
    end
    check("t6_latency", 32'(n), 32'd65);
    check("t6_fail_cnt", 32'(fail_cnt3), 32'd1);
    check("t6_first_fail", 32'(first_fail3), 32'd0);
    check("t6_pass", 32'(pass3), 32'd0);
    check("t6_table", 32'(table3), 32'd0);
    @(posedge clk);
    #1;
    check("t6_done_one_cycle", 32'(done3), 32'd0);

    check("total_dones", 32'(dones), 32'd5);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
